psa_16bit: RTL and testbench
============================

// Module: psa_16bit
// PURPOSE
//  Registered 16-bit partitioned sub-word adder (PSA).
//  Treats A and B as four independent signed 4-bit lanes and adds them lane by lane.
//  No carry propagates between lanes.
//  Sits in the ALU of the single-cycle CPU and serves the PADDSB-style instruction.
//  Error flags signed overflow in any lane.
// PARAMETERS
//  LANES    4   number of sub-word lanes (fixed; 16 = LANES*LANE_W)
//  LANE_W   4   width of each lane in bits (fixed)
// PORTS
//  clk    in   1   rising-edge clock, single clock domain
//  rst_n  in   1   asynchronous active-low reset
//  A      in   16  operand A: lanes A[15:12], A[11:8], A[7:4], A[3:0]
//  B      in   16  operand B, same lane layout
//  Sum    out  16  registered per-lane sums, same lane layout
//  Error  out  1   registered OR of per-lane signed overflow
// BEHAVIOUR
//  - Reset: asserting rst_n low immediately (asynchronously) clears Sum=16'h0000 and Error=0.
//    Registers update again on the first rising clk after rst_n deasserts.
//  - Latency: 1 cycle. A/B sampled at rising clk edge n; Sum/Error are valid after edge n.
//    New operands are accepted every cycle; no handshake.
//  - Per lane i (i=0..3, bits [4i+3:4i]):
//    - raw_i = A_i + B_i (mod 16). Carry-out is discarded, never forwarded to lane i+1.
//    - ovf_i = (A_i[3]==B_i[3]) && (raw_i[3]!=A_i[3]), i.e. signed 4-bit overflow.
//  - Error_next = |ovf[3:0].
//  - Sum_next lane i = raw_i (wrap) unless saturation is compiled in (see CONFIGURATION).
//  - Boundaries:
//    - 4'hF + 4'h1 = 4'h0, ovf=0, no effect on the neighbouring lane.
//    - 4'h8 + 4'h8 = 4'h0, ovf=1.
//    - 4'h7 + 4'h1 = 4'h8, ovf=1.
//    - Several lanes overflowing in the same cycle still give a single Error=1.
//  - Reset asserted mid-operation: the in-flight result is discarded and outputs read 0.
// CONFIGURATION
//  PSA_SATURATE_EN
//  - Defined: an overflowing lane saturates. Positive overflow -> 4'h7, negative overflow -> 4'h8.
//    Non-overflowing lanes are unchanged.
//  - Undefined (default): lanes wrap modulo 16.
//  - Error behaves identically in both builds.
// STRUCTURE
//  - Shared package psa_pkg:
//    - localparams LANES=4, LANE_W=4, SAT_POS=4'h7, SAT_NEG=4'h8.
//    - typedef logic [3:0] lane_t.
//  - Sub-module psa_lane_add (combinational):
//    - 4-bit carry-lookahead adder with generate/propagate logic.
//    - Inputs a, b (lane_t).
//    - Outputs s (lane_t, wrapped or saturated per macro) and ovf.
//    - Instantiated 4x via generate.
//  - Top: lane concatenation, OR-reduce for Error, output register with async clear.
// TESTING
//  1. rst_n=0, A=16'hFFFF, B=16'hFFFF -> Sum=16'h0000, Error=0 immediately, without waiting for a clk edge.
//  2. A=16'h1234, B=16'h1111 -> one cycle later Sum=16'h2345, Error=0.
//  3. A=16'h000F, B=16'h0001 -> Sum=16'h0000, Error=0 (no inter-lane carry).
//  4. A=16'h7000, B=16'h1000 -> Error=1.
//     Sum=16'h8000 (wrap build) or 16'h7000 (PSA_SATURATE_EN build).
//  5. A=16'h8888, B=16'h8888 -> Error=1.
//     Sum=16'h0000 (wrap build) or 16'h8888 (saturating build).
//  6. 100 $random A/B vectors, one per cycle.
//     Compare every lane and Error against a behavioural model, $stop on mismatch.
//     Then toggle rst_n low mid-stream and check outputs clear.

Source files
------------

// File: rtl/psa_pkg.sv
// Shared types and constants for the partitioned sub-word adder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Build option: PSA_SATURATE_EN. When it is defined, overflowing lanes
// saturate. When it is undefined, which is the default, lanes wrap modulo 16.
package psa_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t SAT_POS = 4'h7;
  localparam lane_t SAT_NEG = 4'h8;

`ifdef PSA_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

endpackage

// File: rtl/psa_lane_add.sv
// Purpose: adds one signed 4-bit lane with a carry-lookahead adder and reports signed overflow.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a, b : lane operands (lane_t)
//   s    : lane sum. It wraps, or saturates when PSA_SATURATE_EN is defined.
//   ovf  : signed overflow for this lane
module psa_lane_add
  import psa_pkg::*;
(
  input  lane_t a,
  input  lane_t b,
  output lane_t s,
  output logic  ovf
);

  lane_t g;
  lane_t p;
  lane_t c;    // c[k] is the carry into bit k
  lane_t raw;
  lane_t sat;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries. Lane carry-in is always 0, and carry-out of bit 3 is
  // deliberately never formed: nothing crosses into the neighbouring lane.
  assign c[0] = 1'b0;
  assign c[1] = g[0];
  assign c[2] = g[1] | (p[1] & g[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);

  assign raw = p ^ c;

  // Overflow occurs when both operands have the same sign and the result sign differs.
  assign ovf = (a[3] == b[3]) && (raw[3] != a[3]);

  // The operands share a sign on overflow, so a[3] picks the saturation rail.
  assign sat = a[3] ? SAT_NEG : SAT_POS;

  assign s = (SAT_EN && ovf) ? sat : raw;

endmodule

// File: rtl/psa_16bit.sv
// Purpose: registered 16-bit partitioned adder that treats the operands as four independent signed 4-bit lanes.
// Latency: 1 cycle. A new operand pair is accepted every cycle.
// Backpressure: none. There is no handshake.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset. It clears Sum and Error.
//   A, B  : operands. Lane i occupies bits [4i+3:4i].
//   Sum   : registered per-lane sums in the same lane layout
//   Error : registered OR of the per-lane signed overflow flags
// Build option: PSA_SATURATE_EN. See psa_pkg.
module psa_16bit
  import psa_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*LANE_W-1:0] A,
  input  logic [LANES*LANE_W-1:0] B,
  output logic [LANES*LANE_W-1:0] Sum,
  output logic                    Error
);

  logic [LANES*LANE_W-1:0] sum_nxt;
  logic [LANES-1:0]        ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psa_lane_add u_lane (
      .a   (A[i*LANE_W +: LANE_W]),
      .b   (B[i*LANE_W +: LANE_W]),
      .s   (sum_nxt[i*LANE_W +: LANE_W]),
      .ovf (ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum   <= '0;
      Error <= 1'b0;
    end else begin
      Sum   <= sum_nxt;
      Error <= |ovf;
    end
  end

endmodule

// File: tb/tb_psa_16bit.sv
// Purpose: self-checking bench for psa_16bit using a vector table, a random stream and reset corner cases.
// Latency: expected values are queued when stimulus is driven and compared one cycle later.
// Backpressure: n/a.
module tb_psa_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] sum;
  logic        err;

  always #5 clk = ~clk;

  psa_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a_in),
    .B     (b_in),
    .Sum   (sum),
    .Error (err)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        e;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[9];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Independent signed-integer model of one cycle's result.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] s, output logic e);
    int sa;
    int sb_i;
    int r;
    logic [3:0] la;
    logic [3:0] lb;
    s = '0;
    e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      la   = a[4*i +: 4];
      lb   = b[4*i +: 4];
      sa   = la[3] ? int'(la) - 16 : int'(la);
      sb_i = lb[3] ? int'(lb) - 16 : int'(lb);
      r    = sa + sb_i;
      if (r > 7 || r < -8) begin
        e = 1'b1;
`ifdef PSA_SATURATE_EN
        s[4*i +: 4] = (r > 7) ? 4'h7 : 4'h8;
`else
        s[4*i +: 4] = r[3:0];
`endif
      end else begin
        s[4*i +: 4] = r[3:0];
      end
    end
  endfunction

  // Compare the oldest outstanding expectation against the current outputs.
  task automatic drain_one();
    vec_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check16($sformatf("sum a=%h b=%h", x.a, x.b), sum, x.s);
      check1($sformatf("error a=%h b=%h", x.a, x.b), err, x.e);
    end
  endtask

  // On each falling edge, check the result of the previous pair, then drive the next pair.
  task automatic step(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] es, input logic ee);
    vec_t x;
    @(negedge clk);
    drain_one();
    a_in = a;
    b_in = b;
    x.a = a;
    x.b = b;
    x.s = es;
    x.e = ee;
    sb.push_back(x);
  endtask

  task automatic flush();
    @(negedge clk);
    drain_one();
  endtask

  task automatic random_burst(input int n);
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] es;
    logic        ee;
    for (int k = 0; k < n; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      model(ra, rb, es, ee);
      step(ra, rb, es, ee);
    end
  endtask

  initial begin
`ifdef PSA_SATURATE_EN
    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 1'b0};
    vecs[1] = '{16'h000F, 16'h0001, 16'h0000, 1'b0};
    vecs[2] = '{16'h7000, 16'h1000, 16'h7000, 1'b1};
    vecs[3] = '{16'h8888, 16'h8888, 16'h8888, 1'b1};
    vecs[4] = '{16'h7777, 16'h1111, 16'h7777, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 16'hFFF0, 1'b0};
    vecs[6] = '{16'h8000, 16'hF000, 16'h8000, 1'b1};
    vecs[7] = '{16'h7F81, 16'h1111, 16'h7092, 1'b1};
    vecs[8] = '{16'h0123, 16'h0000, 16'h0123, 1'b0};
`else
    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 1'b0};
    vecs[1] = '{16'h000F, 16'h0001, 16'h0000, 1'b0};
    vecs[2] = '{16'h7000, 16'h1000, 16'h8000, 1'b1};
    vecs[3] = '{16'h8888, 16'h8888, 16'h0000, 1'b1};
    vecs[4] = '{16'h7777, 16'h1111, 16'h8888, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 16'hFFF0, 1'b0};
    vecs[6] = '{16'h8000, 16'hF000, 16'h7000, 1'b1};
    vecs[7] = '{16'h7F81, 16'h1111, 16'h8092, 1'b1};
    vecs[8] = '{16'h0123, 16'h0000, 16'h0123, 1'b0};
`endif

    // Asynchronous reset clears the outputs before any clock edge arrives.
    rst_n = 1'b1;
    a_in  = 16'hFFFF;
    b_in  = 16'hFFFF;
    #1 rst_n = 1'b0;
    #1;
    check16("reset sum async", sum, 16'h0000);
    check1("reset error async", err, 1'b0);

    // The outputs stay clear while clocks run under reset.
    repeat (3) @(posedge clk);
    #1;
    check16("reset sum held", sum, 16'h0000);
    check1("reset error held", err, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e);
    end
    flush();

    // Random stream, one pair per cycle.
    random_burst(50);

    // Assert reset mid-stream, away from a clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check16("midstream reset sum", sum, 16'h0000);
    check1("midstream reset error", err, 1'b0);
    sb.delete();  // the in-flight result is discarded
    @(posedge clk);
    #1;
    check16("midstream reset sum held", sum, 16'h0000);
    check1("midstream reset error held", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    random_burst(50);
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary line");
    $fatal(1);
  end

endmodule
